// File: rtl/fp_misc_arbiter.sv
// Round-robin arbiter sharing one FP misc unit (ABS/NEG/MIN/MAX)
// among NUM_REQ requesters, with a one-entry registered response buffer.
package fp_misc_pkg;
   localparam int DATA_WIDTH = 32;
   typedef enum logic [2:0] {
      FOP_ABS   = 3'd0,
      FOP_NEG   = 3'd1,
      FOP_MIN   = 3'd2,
      FOP_MAX   = 3'd3,
      FOP_SGNJ  = 3'd4,
      FOP_CLASS = 3'd5
   } fpu_op_t;
endpackage

module fp_misc_arbiter
   import fp_misc_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int TAG_W   = 6,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_REQ-1:0]    req_valid,
   output logic [NUM_REQ-1:0]    req_ready,
   input  fpu_op_t               req_op [NUM_REQ],
   input  logic [DATA_WIDTH-1:0] req_a  [NUM_REQ],
   input  logic [DATA_WIDTH-1:0] req_b  [NUM_REQ],
   input  logic [TAG_W-1:0]      req_tag[NUM_REQ],
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic [ID_W-1:0]       rsp_id,
   output logic [TAG_W-1:0]      rsp_tag,
   output logic                  rsp_illegal,
   output logic                  busy
);

   localparam logic [DATA_WIDTH-1:0] QNAN = 32'h7FC0_0000;

   logic                  rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic [ID_W-1:0]       rsp_id_q, rsp_id_d;
   logic [TAG_W-1:0]      rsp_tag_q, rsp_tag_d;
   logic                  rsp_illegal_q, rsp_illegal_d;
   logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;

   logic                  gnt_found;
   logic [ID_W-1:0]       gnt_idx;
   logic                  slot_free;
   logic                  accept;
   fpu_op_t               op;
   logic [DATA_WIDTH-1:0] op_a, op_b;
   logic [DATA_WIDTH-1:0] res;
   logic                  illegal;
   logic                  a_nan, b_nan, a_lt_b;

   function automatic logic is_nan(input logic [DATA_WIDTH-1:0] x);
      return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
   endfunction

   // Signed-magnitude order; +0 and -0 compare equal.
   function automatic logic fp_lt(input logic [DATA_WIDTH-1:0] x,
                                  input logic [DATA_WIDTH-1:0] y);
      logic both_zero;
      both_zero = (x[30:0] == 31'd0) && (y[30:0] == 31'd0);
      if (both_zero)
         return 1'b0;
      if (x[31] != y[31])
         return x[31];
      if (x[31])
         return x[30:0] > y[30:0];
      return x[30:0] < y[30:0];
   endfunction

   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         int cand;
         cand = (int'(rr_ptr_q) + k) % NUM_REQ;
         if (!gnt_found && req_valid[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = ID_W'(cand);
         end
      end
   end

   assign slot_free = !rsp_valid_q || rsp_ready;
   assign accept    = !rst && slot_free && gnt_found;

   always_comb begin
      req_ready = '0;
      if (accept)
         req_ready[gnt_idx] = 1'b1;
   end

   assign op     = req_op[gnt_idx];
   assign op_a   = req_a[gnt_idx];
   assign op_b   = req_b[gnt_idx];
   assign a_nan  = is_nan(op_a);
   assign b_nan  = is_nan(op_b);
   assign a_lt_b = fp_lt(op_a, op_b);

   always_comb begin
      res     = op_a;
      illegal = 1'b0;
      unique case (op)
         FOP_ABS: res = {1'b0, op_a[30:0]};
         FOP_NEG: res = {~op_a[31], op_a[30:0]};
         FOP_MIN, FOP_MAX: begin
            if (a_nan && b_nan)
               res = QNAN;
            else if (a_nan)
               res = op_b;
            else if (b_nan)
               res = op_a;
            else if (op == FOP_MIN)
               res = a_lt_b ? op_a : op_b;
            else
               res = a_lt_b ? op_b : op_a;
         end
         default: illegal = 1'b1;
      endcase
   end

   always_comb begin
      rsp_valid_d   = rsp_valid_q;
      rsp_data_d    = rsp_data_q;
      rsp_id_d      = rsp_id_q;
      rsp_tag_d     = rsp_tag_q;
      rsp_illegal_d = rsp_illegal_q;
      rr_ptr_d      = rr_ptr_q;
      if (accept) begin
         rsp_valid_d   = 1'b1;
         rsp_data_d    = res;
         rsp_id_d      = gnt_idx;
         rsp_tag_d     = req_tag[gnt_idx];
         rsp_illegal_d = illegal;
         if (gnt_idx == ID_W'(NUM_REQ - 1))
            rr_ptr_d = '0;
         else
            rr_ptr_d = gnt_idx + ID_W'(1);
      end else if (rsp_valid_q && rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid_q   <= 1'b0;
         rsp_data_q    <= '0;
         rsp_id_q      <= '0;
         rsp_tag_q     <= '0;
         rsp_illegal_q <= 1'b0;
         rr_ptr_q      <= '0;
      end else begin
         rsp_valid_q   <= rsp_valid_d;
         rsp_data_q    <= rsp_data_d;
         rsp_id_q      <= rsp_id_d;
         rsp_tag_q     <= rsp_tag_d;
         rsp_illegal_q <= rsp_illegal_d;
         rr_ptr_q      <= rr_ptr_d;
      end
   end

   assign rsp_valid   = rsp_valid_q;
   assign rsp_data    = rsp_data_q;
   assign rsp_id      = rsp_id_q;
   assign rsp_tag     = rsp_tag_q;
   assign rsp_illegal = rsp_illegal_q;
   assign busy        = rsp_valid_q || (|req_valid);

endmodule

// File: tb/tb_fp_misc_arbiter.sv
// Bench for fp_misc_arbiter: directed vectors, literal checks and an
// order-key based reference model compared on every negedge.
module tb_fp_misc_arbiter;
   import fp_misc_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req_valid = 4'b0;
   logic [3:0]  req_ready;
   fpu_op_t     req_op [4];
   logic [31:0] req_a  [4];
   logic [31:0] req_b  [4];
   logic [5:0]  req_tag[4];
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [31:0] rsp_data;
   logic [1:0]  rsp_id;
   logic [5:0]  rsp_tag;
   logic        rsp_illegal;
   logic        busy;

   int total = 0;
   int bad   = 0;
   bit started = 0;

   bit          m_valid = 0;
   logic [31:0] m_data  = 0;
   int          m_id    = 0;
   logic [5:0]  m_tag   = 0;
   bit          m_ill   = 0;
   int          m_ptr   = 0;

   int          cg;
   logic [3:0]  exp_rdy;

   fp_misc_arbiter #(.NUM_REQ(4), .TAG_W(6)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_tag(rsp_tag),
      .rsp_illegal(rsp_illegal), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act,
                        input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   function automatic int pick(input logic [3:0] v, input int ptr);
      for (int k = 0; k < 4; k++)
         if (v[(ptr + k) % 4]) return (ptr + k) % 4;
      return -1;
   endfunction

   function automatic bit isnan(input logic [31:0] x);
      return (x[30:23] == 8'hFF) && (x[22:0] != 0);
   endfunction

   // Map a float to a number line position; both zeros land on 0.
   function automatic longint okey(input logic [31:0] x);
      longint mag;
      mag = longint'(x[30:0]);
      return x[31] ? -mag : mag;
   endfunction

   function automatic logic [32:0] fmodel(input fpu_op_t o,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
      if (o == FOP_ABS) return {1'b0, 1'b0, a[30:0]};
      if (o == FOP_NEG) return {1'b0, ~a[31], a[30:0]};
      if (o == FOP_MIN || o == FOP_MAX) begin
         if (isnan(a) && isnan(b)) return {1'b0, 32'h7FC00000};
         if (isnan(a)) return {1'b0, b};
         if (isnan(b)) return {1'b0, a};
         if (o == FOP_MIN) return {1'b0, (okey(a) < okey(b)) ? a : b};
         return {1'b0, (okey(a) < okey(b)) ? b : a};
      end
      return {1'b1, a};
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         started <= 1;
         m_valid <= 0;
         m_data  <= 0;
         m_id    <= 0;
         m_tag   <= 0;
         m_ill   <= 0;
         m_ptr   <= 0;
      end else if (started) begin
         if (pick(req_valid, m_ptr) >= 0 && (!m_valid || rsp_ready)) begin
            m_valid <= 1;
            {m_ill, m_data} <= fmodel(req_op[pick(req_valid, m_ptr)],
                                      req_a[pick(req_valid, m_ptr)],
                                      req_b[pick(req_valid, m_ptr)]);
            m_id  <= pick(req_valid, m_ptr);
            m_tag <= req_tag[pick(req_valid, m_ptr)];
            m_ptr <= (pick(req_valid, m_ptr) + 1) % 4;
         end else if (m_valid && rsp_ready) begin
            m_valid <= 0;
         end
      end
   end

   always @(negedge clk) begin
      if (started) begin
         cg = pick(req_valid, m_ptr);
         exp_rdy = 4'b0;
         if (!rst && (!m_valid || rsp_ready) && cg >= 0)
            exp_rdy[cg] = 1'b1;
         check("m_req_ready", 64'(req_ready), 64'(exp_rdy));
         check("m_rsp_valid", 64'(rsp_valid), 64'(m_valid));
         check("m_rsp_data", 64'(rsp_data), 64'(m_data));
         check("m_rsp_id", 64'(rsp_id), 64'(m_id));
         check("m_rsp_tag", 64'(rsp_tag), 64'(m_tag));
         check("m_rsp_illegal", 64'(rsp_illegal), 64'(m_ill));
         check("m_busy", 64'(busy), 64'(m_valid || (|req_valid)));
      end
   end

   task automatic issue(input int r, input fpu_op_t o, input logic [31:0] a,
                        input logic [31:0] b, input logic [5:0] t);
      @(posedge clk);
      #1;
      req_op[r]  = o;
      req_a[r]   = a;
      req_b[r]   = b;
      req_tag[r] = t;
      req_valid  = 4'b0;
      req_valid[r] = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 4'b0;
      @(negedge clk);
      check("issue_valid", 64'(rsp_valid), 64'd1);
   endtask

   initial begin
      for (int i = 0; i < 4; i++) begin
         req_op[i]  = FOP_ABS;
         req_a[i]   = 0;
         req_b[i]   = 0;
         req_tag[i] = 0;
      end
      req_valid = 4'b1111;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
      check("reset_req_ready", 64'(req_ready), 64'd0);
      check("reset_rsp_data", 64'(rsp_data), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      req_valid = 4'b0;

      issue(2, FOP_ABS, 32'hBF800000, 32'h0, 6'd5);
      check("abs_data", 64'(rsp_data), 64'h3F800000);
      check("abs_id", 64'(rsp_id), 64'd2);
      check("abs_tag", 64'(rsp_tag), 64'd5);
      check("abs_illegal", 64'(rsp_illegal), 64'd0);
      issue(0, FOP_MIN, 32'h3F800000, 32'hBF800000, 6'd1);
      check("min_data", 64'(rsp_data), 64'hBF800000);
      issue(1, FOP_MAX, 32'h7FC00001, 32'h40000000, 6'd2);
      check("max_onenan", 64'(rsp_data), 64'h40000000);
      issue(3, FOP_MAX, 32'h7FC00001, 32'hFFC00000, 6'd3);
      check("max_bothnan", 64'(rsp_data), 64'h7FC00000);
      issue(0, FOP_MIN, 32'h80000000, 32'h00000000, 6'd4);
      check("min_zeros", 64'(rsp_data), 64'h00000000);
      issue(2, FOP_MAX, 32'h00000000, 32'h80000000, 6'd6);
      check("max_zeros", 64'(rsp_data), 64'h00000000);
      issue(1, FOP_NEG, 32'h3F800000, 32'h0, 6'd7);
      check("neg_data", 64'(rsp_data), 64'hBF800000);
      issue(3, fpu_op_t'(3'd5), 32'h12345678, 32'h0, 6'd9);
      check("ill_data", 64'(rsp_data), 64'h12345678);
      check("ill_flag", 64'(rsp_illegal), 64'd1);

      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      req_op[0] = FOP_NEG; req_a[0] = 32'h3F800000; req_tag[0] = 6'd10;
      req_op[1] = FOP_ABS; req_a[1] = 32'hC0400000; req_tag[1] = 6'd11;
      req_op[2] = FOP_MIN; req_a[2] = 32'h40400000; req_b[2] = 32'hC0000000;
      req_tag[2] = 6'd12;
      req_op[3] = FOP_MAX; req_a[3] = 32'h40400000; req_b[3] = 32'hC0000000;
      req_tag[3] = 6'd13;
      req_valid = 4'b1111;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         @(negedge clk);
         check("rr_id", 64'(rsp_id), 64'(i % 4));
         check("rr_valid", 64'(rsp_valid), 64'd1);
      end

      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_ready", 64'(req_ready), 64'd0);
         check("bp_id", 64'(rsp_id), 64'd2);
         check("bp_data", 64'(rsp_data), 64'hC0000000);
         @(posedge clk);
      end
      #1;
      rsp_ready = 1'b1;
      @(negedge clk);
      check("bp_release_ready", 64'(req_ready), 64'b1000);
      @(posedge clk);
      @(negedge clk);
      check("bp_release_id", 64'(rsp_id), 64'd3);
      check("bp_release_data", 64'(rsp_data), 64'h40400000);

      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      check("pre_rst_valid", 64'(rsp_valid), 64'd1);
      @(posedge clk);
      @(negedge clk);
      check("mid_rst_valid", 64'(rsp_valid), 64'd0);
      #1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      rsp_ready = 1'b1;
      req_valid = 4'b1010;
      @(negedge clk);
      check("post_rst_ready", 64'(req_ready), 64'b0010);
      @(posedge clk);
      @(negedge clk);
      check("post_rst_id", 64'(rsp_id), 64'd1);
      @(posedge clk);
      #1;
      req_valid = 4'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("drained", 64'(rsp_valid), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
